tlc_param: RTL and testbench

Parametrised successor of the two-road (highway/farm) traffic light controller. Adds configurable phase timings, minimum and maximum green times, an all-red clearance interval, a synchronised farm sensor, a latched pedestrian request with a walk output, and a tick enable for slow-time operation. Instantiated under the tt_um_* top. The top maps ui_in/uo_out onto these ports.

---
 rtl/tlc_param_if.sv | 24 ++
 rtl/tlc_param.sv | 123 ++++++++++++
 tb/tb_tlc_param.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tlc_param_if.sv
// Signal bundle between the traffic light controller and its surroundings.
// The master drives the enable, sensor and request inputs; the slave is the controller.
interface tlc_param_if #(
  parameter int unsigned CW = 8
) ();
  logic          ena;
  logic          sensor_c;
  logic          ped_req;
  logic [2:0]    light_hwy;
  logic [2:0]    light_farm;
  logic          ped_walk;
  logic [2:0]    state_o;
  logic [CW-1:0] timer_o;

  modport master (
    output ena, sensor_c, ped_req,
    input  light_hwy, light_farm, ped_walk, state_o, timer_o
  );

  modport slave (
    input  ena, sensor_c, ped_req,
    output light_hwy, light_farm, ped_walk, state_o, timer_o
  );
endinterface

// File: rtl/tlc_param.sv
// Highway/farm traffic light controller with parametrised phase timing,
// a synchronised farm sensor, a latched pedestrian request and a tick enable.
module tlc_param #(
  parameter int unsigned CW          = 8,
  parameter int unsigned T_HMIN      = 10,
  parameter int unsigned T_YEL       = 3,
  parameter int unsigned T_AR        = 1,
  parameter int unsigned T_FMIN      = 4,
  parameter int unsigned T_FMAX      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  tlc_param_if.slave  bus
);

  typedef enum logic [2:0] {
    StHg  = 3'd0,
    StHy  = 3'd1,
    StAr1 = 3'd2,
    StFg  = 3'd3,
    StFy  = 3'd4,
    StAr2 = 3'd5
  } state_e;

  localparam int unsigned TMax = (1 << CW) - 1;

  if (SYNC_STAGES < 2 || CW < 1 || CW > 31 ||
      T_HMIN < 1 || T_HMIN > TMax || T_YEL < 1 || T_YEL > TMax ||
      T_AR < 1 || T_AR > TMax || T_FMIN < 1 || T_FMIN > TMax ||
      T_FMAX < 1 || T_FMAX > TMax || T_FMIN > T_FMAX) begin : g_bad_params
    $error("tlc_param: illegal parameter combination");
  end

  localparam logic [CW-1:0] HMinM1 = CW'(T_HMIN - 1);
  localparam logic [CW-1:0] YelM1  = CW'(T_YEL - 1);
  localparam logic [CW-1:0] ArM1   = CW'(T_AR - 1);
  localparam logic [CW-1:0] FMinM1 = CW'(T_FMIN - 1);
  localparam logic [CW-1:0] FMaxM1 = CW'(T_FMAX - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   c_s;
  state_e                 state_q, state_d, state_nxt;
  logic [CW-1:0]          timer_q, timer_d;
  logic                   pend_q, pend_d;
  logic                   go, illegal;
  logic [2:0]             hwy_q, farm_q;
  logic                   walk_q;

  assign c_s = sync_q[SYNC_STAGES-1];

  // Lamp pattern {hwy, farm, walk} for a state; unknown encodings show all red.
  function automatic logic [6:0] decode(state_e s);
    case (s)
      StHg:    return {3'b001, 3'b100, 1'b0};
      StHy:    return {3'b010, 3'b100, 1'b0};
      StFg:    return {3'b100, 3'b001, 1'b1};
      StFy:    return {3'b100, 3'b010, 1'b0};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  always_comb begin
    go        = 1'b0;
    illegal   = 1'b0;
    state_nxt = StHg;
    case (state_q)
      StHg:  begin go = (timer_q >= HMinM1) && (c_s || pend_q); state_nxt = StHy;  end
      StHy:  begin go = (timer_q == YelM1);                     state_nxt = StAr1; end
      StAr1: begin go = (timer_q == ArM1);                      state_nxt = StFg;  end
      StFg:  begin
        go        = (timer_q == FMaxM1) || ((timer_q >= FMinM1) && !c_s);
        state_nxt = StFy;
      end
      StFy:  begin go = (timer_q == YelM1);                     state_nxt = StAr2; end
      StAr2: begin go = (timer_q == ArM1);                      state_nxt = StHg;  end
      default: illegal = 1'b1;
    endcase

    state_d = state_q;
    timer_d = timer_q;
    if (illegal) begin
      // Recovery does not wait for a tick.
      state_d = StHg;
      timer_d = '0;
    end else if (bus.ena) begin
      if (go) begin
        state_d = state_nxt;
        timer_d = '0;
      end else if (timer_q != '1) begin
        timer_d = timer_q + 1'b1;
      end
    end

    // Entering FG serves any pending request, including one arriving this edge.
    pend_d = (state_q == StAr1 && state_d == StFg) ? 1'b0 : (pend_q | bus.ped_req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= StHg;
      timer_q <= '0;
      pend_q  <= 1'b0;
      hwy_q   <= 3'b001;
      farm_q  <= 3'b100;
      walk_q  <= 1'b0;
    end else begin
      sync_q                   <= {sync_q[SYNC_STAGES-2:0], bus.sensor_c};
      state_q                  <= state_d;
      timer_q                  <= timer_d;
      pend_q                   <= pend_d;
      {hwy_q, farm_q, walk_q}  <= decode(state_d);
    end
  end

  assign bus.light_hwy  = hwy_q;
  assign bus.light_farm = farm_q;
  assign bus.ped_walk   = walk_q;
  assign bus.state_o    = state_q;
  assign bus.timer_o    = timer_q;

endmodule

// File: tb/tb_tlc_param.sv
// Randomised scoreboard bench for tlc_param against a phase/elapsed-time model.
module tb_tlc_param;
  localparam int unsigned CW = 8, T_HMIN = 10, T_YEL = 3, T_AR = 1;
  localparam int unsigned T_FMIN = 4, T_FMAX = 10, SYNC_STAGES = 2;

  logic clk, rst_n;
  tlc_param_if #(.CW(CW)) bus ();

  tlc_param #(
    .CW(CW), .T_HMIN(T_HMIN), .T_YEL(T_YEL), .T_AR(T_AR),
    .T_FMIN(T_FMIN), .T_FMAX(T_FMAX), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Expected {hwy, farm, walk, state, timer} per clock edge.
  logic [17:0] sb[$];

  // Reference model: phase index, ticks spent in it, pending pedestrian, sensor pipeline.
  int m_phase, m_t;
  bit m_pend;
  bit sh[$];

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_pend  = 1'b0;
    sh.delete();
    for (int i = 0; i < SYNC_STAGES; i++) sh.push_back(1'b0);
  endtask

  function automatic logic [17:0] model_out();
    logic [2:0] h, f;
    h = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
    f = (m_phase == 3) ? 3'b001 : (m_phase == 4) ? 3'b010 : 3'b100;
    return {h, f, 1'(m_phase == 3), 3'(m_phase), 8'(m_t)};
  endfunction

  task automatic model_edge(input bit e, input bit s, input bit p);
    bit cs, adv;
    int len;
    cs  = sh.pop_front();
    sh.push_back(s);
    adv = 1'b0;
    if (e) begin
      len = (m_phase == 2 || m_phase == 5) ? T_AR : T_YEL;
      if (m_phase == 0)      adv = (m_t >= T_HMIN - 1) && (cs || m_pend);
      else if (m_phase == 3) adv = (m_t == T_FMAX - 1) || (m_t >= T_FMIN - 1 && !cs);
      else                   adv = (m_t == len - 1);
      if (adv) begin
        m_phase = (m_phase + 1) % 6;
        m_t     = 0;
      end else if (m_t < 255) begin
        m_t++;
      end
    end
    m_pend = (adv && m_phase == 3) ? 1'b0 : (m_pend | p);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit e, input bit s, input bit p);
    bus.ena      = e;
    bus.sensor_c = s;
    bus.ped_req  = p;
    @(posedge clk);
    if (rst_n) begin
      model_edge(e, s, p);
      sb.push_back(model_out());
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    logic [17:0] act;
    act = {bus.light_hwy, bus.light_farm, bus.ped_walk, bus.state_o, bus.timer_o};
    checks++;
    if (act !== {3'b001, 3'b100, 1'b0, 3'd0, 8'd0}) begin
      failures++;
      $display("FAIL %s: got %b, want 001_100_0_000_00000000", name, act);
    end
  endtask

  // Asynchronous reset between edges, held across one posedge.
  task automatic do_reset(input string name);
    #1 rst_n = 1'b0;
    #1 check_reset(name);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected word per modelled edge, compared just after the edge.
  initial begin
    logic [17:0] exp_w, act_w;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        act_w = {bus.light_hwy, bus.light_farm, bus.ped_walk, bus.state_o, bus.timer_o};
        checks++;
        if (act_w !== exp_w) begin
          failures++;
          $display("FAIL outputs @%0t: got hwy=%b farm=%b walk=%b st=%0d tm=%0d, want hwy=%b farm=%b walk=%b st=%0d tm=%0d",
                   $time, act_w[17:15], act_w[14:12], act_w[11], act_w[10:8], act_w[7:0],
                   exp_w[17:15], exp_w[14:12], exp_w[11], exp_w[10:8], exp_w[7:0]);
        end
        checks++;
        if ((bus.light_hwy != 3'b100 && bus.light_farm != 3'b100) ||
            !$onehot(bus.light_hwy) || !$onehot(bus.light_farm)) begin
          failures++;
          $display("FAIL lamp_safety @%0t: got hwy=%b farm=%b, want one-hot with a red road",
                   $time, bus.light_hwy, bus.light_farm);
        end
      end
    end
  end

  initial begin
    bit sens;
    int i;
    rst_n        = 1'b0;
    bus.ena      = 1'b0;
    bus.sensor_c = 1'b0;
    bus.ped_req  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("reset_init");
    rst_n = 1'b1;

    // Idle: no demand keeps highway green, timer counts to 50.
    repeat (50) step(1'b1, 1'b0, 1'b0);

    // Pedestrian pulse while ticks are disabled must be remembered.
    do_reset("reset_before_ped");
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b0, 1'b0);

    // Continuous farm demand: full cycle with max-green cap.
    do_reset("reset_before_sensor");
    repeat (60) step(1'b1, 1'b1, 1'b0);

    // Demand drops two ticks into FG: min-green applies.
    for (i = 0; i < 100 && !(m_phase == 3 && m_t == 2); i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if (!(m_phase == 3 && m_t == 2)) begin
      failures++;
      $display("FAIL reach_fg2: got phase=%0d t=%0d, want phase=3 t=2", m_phase, m_t);
    end
    repeat (20) step(1'b1, 1'b0, 1'b0);

    // Alternating enable stretches every phase.
    for (i = 0; i < 80; i++) step(i % 2 == 0, 1'b1, 1'b0);

    // Reset in the middle of farm green.
    for (i = 0; i < 100 && !(m_phase == 3 && m_t == 5); i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if (!(m_phase == 3 && m_t == 5)) begin
      failures++;
      $display("FAIL reach_fg5: got phase=%0d t=%0d, want phase=3 t=5", m_phase, m_t);
    end
    do_reset("reset_mid_fg");
    repeat (30) step(1'b1, 1'b0, 1'b0);

    // Random traffic.
    sens = 1'b0;
    for (i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) sens = ~sens;
      if ($urandom_range(599) == 0) do_reset("reset_random");
      step($urandom_range(3) != 0, sens, $urandom_range(31) == 0);
    end

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
